truth_table_sweeper: RTL and testbench
======================================

// Module: truth_table_sweeper
// PURPOSE
//  Parametrised, registered N-input truth-table function unit with a built-in exhaustive self-check sweep.
//  Evaluates a 2^N-bit lookup table on an input vector with one-cycle latency.
//  On request, walks all 2^N input codes and compares each against an expected table.
//  Counts mismatches and records the first failing code.
//  Sits between input decode logic and downstream control; the sweep provides in-system self-check of the function.
// PARAMETERS
//  N_IN   4         number of function inputs; table depth DEPTH = 2**N_IN
//  TABLE  16'hD4C0  reset/default truth table; bit i = output for input code i (MSB of in_vec = input r)
// PORTS
//  clk            in   1         rising-edge clock
//  rst_n          in   1         asynchronous active-low reset
//  in_vec         in   N_IN      input code to evaluate
//  in_valid       in   1         in_vec is valid this cycle
//  out_bit        out  1         registered function value
//  out_valid      out  1         out_bit is valid (one cycle after an accepted in_valid)
//  cfg_we         in   1         table write strobe (present only with TT_RELOAD_EN)
//  cfg_table      in   DEPTH     new table value (present only with TT_RELOAD_EN)
//  start          in   1         one-cycle pulse that begins a sweep
//  exp_table      in   DEPTH     expected table; sampled on accepted start
//  busy           out  1         sweep in progress
//  done           out  1         one-cycle pulse when the sweep finishes
//  err_cnt        out  N_IN+1    mismatch count of the last sweep (0..DEPTH, no overflow)
//  first_err_idx  out  N_IN      lowest failing code of the last sweep
//  first_err_vld  out  1         first_err_idx is meaningful
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - table = TABLE; state IDLE.
//   - All outputs 0; err_cnt, first_err_idx and first_err_vld cleared.
//  Evaluation:
//   - In IDLE or DONE, in_valid=1 at edge k gives out_valid=1 and out_bit=table[in_vec] after edge k.
//   - out_valid is 0 in every other cycle; while busy=1, in_valid is ignored.
//  FSM (IDLE -> SWEEP -> DONE -> IDLE):
//   - IDLE: start=1 -> SWEEP. Capture exp_table; clear err_cnt, first_err_vld and first_err_idx; idx=0; busy=1.
//   - SWEEP, each cycle: if table[idx] != exp[idx] then err_cnt+1, and on the first mismatch record idx and set first_err_vld.
//   - SWEEP: idx increments; after idx==DEPTH-1 is compared -> DONE. busy is high for exactly DEPTH cycles.
//   - DONE: done=1 and busy=0 for one cycle -> IDLE. A start arriving in DONE is accepted as in IDLE.
//   - Results hold until the next accepted start.
//  Boundaries:
//   - start while busy: ignored.
//   - start together with in_valid in IDLE: evaluation completes; the sweep begins the same edge.
//   - idx wraps only at sweep end; it never re-enters 0 inside one sweep.
//   - Reset mid-sweep: immediate return to reset state; no done pulse.
// CONFIGURATION
//  TT_RELOAD_EN defined:
//   - cfg_we/cfg_table ports exist; cfg_we=1 in IDLE/DONE loads the table at that edge.
//   - in_valid in the same cycle evaluates against the OLD table.
//   - cfg_we while busy is ignored, so the table is frozen during a sweep.
//  Not defined: ports absent; table is constant TABLE.
// STRUCTURE
//  Package tt_sweep_pkg: state enum {S_IDLE,S_SWEEP,S_DONE}; DEPTH localparam function of N_IN.
//  Sub-module tt_lut_core: table storage, optional reload, registered eval; shared read port muxed between in_vec and sweep idx.
//  Top: FSM, idx counter, exp capture register, error counters.
// TESTING
//  1. Reset, no stimulus -> out_valid=0, busy=0, done=0, err_cnt=0, first_err_vld=0.
//  2. Defaults: drive codes 0..15 with in_valid -> out_bit matches 16'hD4C0 (6->1, 11->0, 12->1, 13->0), one-cycle latency.
//  3. start with exp_table=16'hD4C0 -> busy high 16 cycles, done pulse, err_cnt=0, first_err_vld=0.
//  4. start with exp_table=16'hD4C1 -> err_cnt=1, first_err_idx=0; with 16'h2B3F -> err_cnt=16, first_err_idx=0.
//  5. Re-pulse start mid-sweep, then assert rst_n=0 at idx 7 -> first start ignored; after reset busy=0, no done, err_cnt=0.
//  6. TT_RELOAD_EN: cfg_table=16'h8000 with in_valid, in_vec=15 same cycle -> out_bit=1 (old table); next code 14 -> 0; cfg_we while busy ignored.

Source files
------------

// File: rtl/tt_sweep_pkg.sv
// Shared types for the truth-table sweeper: sweep FSM state encoding and table depth helper.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    function automatic int depth_of(input int n_in);
        return 2 ** n_in;
    endfunction

endpackage

// File: rtl/tt_lut_core.sv
// Truth-table storage with a single read port shared by evaluation and sweep, plus registered evaluation.
// Optional table reload through cfg_we/cfg_table when TT_RELOAD_EN is defined.
module tt_lut_core
    import tt_sweep_pkg::*;
#(
    parameter int                                N_IN  = 4,
    parameter logic [tt_sweep_pkg::depth_of(N_IN)-1:0] TABLE = 16'hD4C0
) (
    input  logic                      clk,
    input  logic                      rst_n,
`ifdef TT_RELOAD_EN
    input  logic                      cfg_we,
    input  logic [depth_of(N_IN)-1:0] cfg_table,
`endif
    input  logic [N_IN-1:0]           in_vec,
    input  logic                      in_valid,
    input  logic                      sweep_active,
    input  logic [N_IN-1:0]           sweep_idx,
    output logic                      rd_bit,
    output logic                      out_bit,
    output logic                      out_valid
);

    localparam int DEPTH = depth_of(N_IN);

    logic [DEPTH-1:0] table_q;
    logic [N_IN-1:0]  rd_addr;
    logic             accept;

`ifdef TT_RELOAD_EN
    // Table is frozen while a sweep runs so the self-check sees a stable function.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            table_q <= TABLE;
        end else if (cfg_we && !sweep_active) begin
            table_q <= cfg_table;
        end
    end
`else
    assign table_q = TABLE;
`endif

    assign rd_addr = sweep_active ? sweep_idx : in_vec;
    assign rd_bit  = table_q[rd_addr];
    assign accept  = in_valid && !sweep_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
        end else begin
            out_valid <= accept;
            out_bit   <= accept && rd_bit;
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Registered N-input truth-table unit with an exhaustive self-check sweep against an expected table.
// Define TT_RELOAD_EN to add the cfg_we/cfg_table table reload ports.
module truth_table_sweeper
    import tt_sweep_pkg::*;
#(
    parameter int                                N_IN  = 4,
    parameter logic [tt_sweep_pkg::depth_of(N_IN)-1:0] TABLE = 16'hD4C0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_IN-1:0]           in_vec,
    input  logic                      in_valid,
    output logic                      out_bit,
    output logic                      out_valid,
`ifdef TT_RELOAD_EN
    input  logic                      cfg_we,
    input  logic [depth_of(N_IN)-1:0] cfg_table,
`endif
    input  logic                      start,
    input  logic [depth_of(N_IN)-1:0] exp_table,
    output logic                      busy,
    output logic                      done,
    output logic [N_IN:0]             err_cnt,
    output logic [N_IN-1:0]           first_err_idx,
    output logic                      first_err_vld
);

    localparam int DEPTH = depth_of(N_IN);

    state_t           state;
    logic [N_IN-1:0]  idx;
    logic [DEPTH-1:0] exp_q;
    logic             sweep_active;
    logic             rd_bit;
    logic             mismatch;

    assign sweep_active = (state == S_SWEEP);
    assign busy         = sweep_active;
    assign done         = (state == S_DONE);
    assign mismatch     = sweep_active && (rd_bit != exp_q[idx]);

    tt_lut_core #(
        .N_IN  (N_IN),
        .TABLE (TABLE)
    ) u_core (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef TT_RELOAD_EN
        .cfg_we       (cfg_we),
        .cfg_table    (cfg_table),
`endif
        .in_vec       (in_vec),
        .in_valid     (in_valid),
        .sweep_active (sweep_active),
        .sweep_idx    (idx),
        .rd_bit       (rd_bit),
        .out_bit      (out_bit),
        .out_valid    (out_valid)
    );

    // Results from the previous sweep stay visible until a new start is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            idx           <= '0;
            exp_q         <= '0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            first_err_vld <= 1'b0;
        end else begin
            case (state)
                S_SWEEP: begin
                    if (mismatch) begin
                        err_cnt <= err_cnt + (N_IN+1)'(1);
                        if (!first_err_vld) begin
                            first_err_idx <= idx;
                            first_err_vld <= 1'b1;
                        end
                    end
                    idx <= idx + N_IN'(1);
                    if (idx == N_IN'(DEPTH - 1)) begin
                        state <= S_DONE;
                    end
                end
                default: begin
                    if (start) begin
                        state         <= S_SWEEP;
                        exp_q         <= exp_table;
                        idx           <= '0;
                        err_cnt       <= '0;
                        first_err_idx <= '0;
                        first_err_vld <= 1'b0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: vector table for evaluation plus hand-written sweep sequences.
// Reload checks run only when TT_RELOAD_EN is defined.
module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  in_vec = '0;
    logic        in_valid = 1'b0;
    logic        out_bit;
    logic        out_valid;
    logic        start = 1'b0;
    logic [15:0] exp_table = '0;
    logic        busy;
    logic        done;
    logic [4:0]  err_cnt;
    logic [3:0]  first_err_idx;
    logic        first_err_vld;
`ifdef TT_RELOAD_EN
    logic        cfg_we = 1'b0;
    logic [15:0] cfg_table = '0;
`endif

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [3:0] code;
        logic       exp_bit;
    } vec_t;

    vec_t vecs[16];

    always #5 clk = ~clk;

    truth_table_sweeper #(.N_IN(4), .TABLE(16'hD4C0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_vec        (in_vec),
        .in_valid      (in_valid),
        .out_bit       (out_bit),
        .out_valid     (out_valid),
`ifdef TT_RELOAD_EN
        .cfg_we        (cfg_we),
        .cfg_table     (cfg_table),
`endif
        .start         (start),
        .exp_table     (exp_table),
        .busy          (busy),
        .done          (done),
        .err_cnt       (err_cnt),
        .first_err_idx (first_err_idx),
        .first_err_vld (first_err_vld)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] code);
        in_vec   = code;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Pulses start, counts busy cycles under a bound, then checks the sweep results.
    task automatic run_sweep(input logic [15:0] expv, input int req_err,
                             input int req_idx, input logic req_vld);
        int cnt;
        exp_table = expv;
        start     = 1'b1;
        tick();
        start = 1'b0;
        cnt   = 0;
        while (busy && cnt < 40) begin
            cnt++;
            tick();
        end
        check_output("sweep_busy_cycles", cnt, 16);
        check_output("sweep_done_pulse", done, 1);
        check_output("sweep_err_cnt", err_cnt, req_err);
        check_output("sweep_first_vld", first_err_vld, req_vld);
        if (req_vld) check_output("sweep_first_idx", first_err_idx, req_idx);
        tick();
        check_output("sweep_done_cleared", done, 0);
    endtask

    initial begin
        vecs[0]  = '{4'd0,  1'b0};
        vecs[1]  = '{4'd1,  1'b0};
        vecs[2]  = '{4'd2,  1'b0};
        vecs[3]  = '{4'd3,  1'b0};
        vecs[4]  = '{4'd4,  1'b0};
        vecs[5]  = '{4'd5,  1'b0};
        vecs[6]  = '{4'd6,  1'b1};
        vecs[7]  = '{4'd7,  1'b1};
        vecs[8]  = '{4'd8,  1'b0};
        vecs[9]  = '{4'd9,  1'b0};
        vecs[10] = '{4'd10, 1'b1};
        vecs[11] = '{4'd11, 1'b0};
        vecs[12] = '{4'd12, 1'b1};
        vecs[13] = '{4'd13, 1'b0};
        vecs[14] = '{4'd14, 1'b1};
        vecs[15] = '{4'd15, 1'b1};

        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_output("rst_out_valid", out_valid, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_done", done, 0);
        check_output("rst_err_cnt", err_cnt, 0);
        check_output("rst_first_vld", first_err_vld, 0);

        for (int i = 0; i < 16; i++) begin
            apply_stimulus(vecs[i].code);
            check_output($sformatf("eval_valid_%0d", i), out_valid, 1);
            check_output($sformatf("eval_bit_%0d", i), out_bit, vecs[i].exp_bit);
        end
        tick();
        check_output("eval_valid_drops", out_valid, 0);

        run_sweep(16'hD4C0, 0, 0, 1'b0);
        run_sweep(16'hD4C1, 1, 0, 1'b1);
        run_sweep(16'h2B3F, 16, 0, 1'b1);
        run_sweep(16'hDC80, 2, 6, 1'b1);
        tick();
        tick();
        check_output("results_hold_err", err_cnt, 2);
        check_output("results_hold_idx", first_err_idx, 6);

        // start together with in_valid: evaluation completes and sweep begins on the same edge
        in_vec    = 4'd6;
        in_valid  = 1'b1;
        start     = 1'b1;
        exp_table = 16'hD4C0;
        tick();
        start = 1'b0;
        check_output("combo_eval_valid", out_valid, 1);
        check_output("combo_eval_bit", out_bit, 1);
        check_output("combo_busy", busy, 1);
        in_vec = 4'd7;
        tick();
        in_valid = 1'b0;
        check_output("busy_ignores_in_valid", out_valid, 0);
        for (int i = 0; i < 40 && busy; i++) tick();
        check_output("combo_done", done, 1);
        check_output("combo_err_cnt", err_cnt, 0);
        tick();

        // restart while busy is ignored; reset at idx 7 aborts without a done pulse
        exp_table = 16'h2B3F;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        exp_table = 16'hD4C0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check_output("midsweep_busy", busy, 1);
        check_output("midsweep_err_cnt", err_cnt, 7);
        rst_n = 1'b0;
        #1;
        check_output("abort_busy", busy, 0);
        check_output("abort_done", done, 0);
        check_output("abort_err_cnt", err_cnt, 0);
        check_output("abort_first_vld", first_err_vld, 0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("abort_no_done", done, 0);
        end

`ifdef TT_RELOAD_EN
        cfg_table = 16'h8000;
        cfg_we    = 1'b1;
        apply_stimulus(4'd15);
        cfg_we = 1'b0;
        check_output("reload_old_table", out_bit, 1);
        apply_stimulus(4'd14);
        check_output("reload_new_table", out_bit, 0);
        exp_table = 16'h8000;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        cfg_table = 16'hFFFF;
        cfg_we    = 1'b1;
        for (int i = 0; i < 40 && busy; i++) tick();
        cfg_we = 1'b0;
        check_output("reload_frozen_err", err_cnt, 0);
        tick();
        apply_stimulus(4'd0);
        check_output("reload_kept_table", out_bit, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
